// File: rtl/paddle_ctrl.sv
// paddle_ctrl: turns one player's quadrature rotary encoder into a 32-row paddle bitmap.
// An optional auto mode moves the paddle toward the ball row, one row every AUTO_DIV cycles.
//
// Ports:
//   clk     in   system clock
//   reset   in   synchronous reset, active-high
//   enc_a   in   encoder phase A (asynchronous)
//   enc_b   in   encoder phase B (asynchronous)
//   auto    in   1 = computer-controlled paddle
//   ball_y  in   current ball row (0..31), used in auto mode only
//   pos     out  top row of the paddle, 0..32-PADDLE_LEN
//   paddle  out  bit i set iff pos <= i < pos+PADDLE_LEN (registered from pos)
module paddle_ctrl #(
    parameter int unsigned PADDLE_LEN = 5,
    parameter int unsigned STEPS      = 4,
    parameter int unsigned AUTO_DIV   = 64,
    parameter bit          INVERT     = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enc_a,
    input  logic        enc_b,
    input  logic        auto,
    input  logic [4:0]  ball_y,
    output logic [4:0]  pos,
    output logic [31:0] paddle
);

    localparam int unsigned         MaxPos  = 32 - PADDLE_LEN;
    localparam logic [4:0]          MaxPosL = 5'(MaxPos);
    localparam logic [4:0]          RstPos  = 5'(MaxPos / 2);
    localparam int unsigned         DivW    = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
    localparam logic [DivW-1:0]     DivLast = DivW'(AUTO_DIV - 1);
    localparam logic [4:0]          StepsP  = 5'(STEPS);
    localparam logic [4:0]          StepsN  = 5'(-int'(STEPS));

    // Position along the 00->01->11->10 cycle, so a legal move is a +/-1 difference mod 4.
    function automatic logic [1:0] gray_idx(input logic [1:0] s);
        return {s[1], s[1] ^ s[0]};
    endfunction

    function automatic logic [31:0] mask(input logic [4:0] p);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) begin
            m[i] = (i >= int'(p)) && (i < int'(p) + int'(PADDLE_LEN));
        end
        return m;
    endfunction

    logic [1:0]      a_q, b_q;
    logic [1:0]      prev_q;
    logic            up_q, dn_q, up_d, dn_d;
    logic [3:0]      acc_q, acc_d;
    logic [DivW-1:0] div_q, div_d;
    logic [4:0]      pos_q, pos_d;
    logic [31:0]     paddle_q;

    logic [1:0]        s;
    logic [1:0]        diff;
    logic [4:0]        sum;
    logic signed [5:0] tgt_raw;
    logic [4:0]        tgt;

    assign s = {a_q[1], b_q[1]};

    // Decode is registered so a step reaches acc/pos three edges after the input is sampled.
    always_comb begin
        diff = gray_idx(s) - gray_idx(prev_q);
        up_d = INVERT ? (diff == 2'd3) : (diff == 2'd1);
        dn_d = INVERT ? (diff == 2'd1) : (diff == 2'd3);
    end

    always_comb begin
        acc_d   = acc_q;
        pos_d   = pos_q;
        div_d   = div_q;
        sum     = {acc_q[3], acc_q} + {4'b0, up_q} - {4'b0, dn_q};
        tgt_raw = signed'({1'b0, ball_y}) - signed'(6'(PADDLE_LEN / 2));
        if (tgt_raw < 6'sd0) begin
            tgt = 5'd0;
        end else if (tgt_raw > signed'(6'(MaxPos))) begin
            tgt = MaxPosL;
        end else begin
            tgt = tgt_raw[4:0];
        end

        if (auto) begin
            acc_d = 4'd0;
            if (div_q == DivLast) begin
                div_d = '0;
                if (pos_q < tgt) begin
                    pos_d = pos_q + 5'd1;
                end else if (pos_q > tgt) begin
                    pos_d = pos_q - 5'd1;
                end
            end else begin
                div_d = div_q + DivW'(1);
            end
        end else begin
            div_d = '0;
            if (sum == StepsP) begin
                acc_d = 4'd0;
                if (pos_q != MaxPosL) begin
                    pos_d = pos_q + 5'd1;
                end
            end else if (sum == StepsN) begin
                acc_d = 4'd0;
                if (pos_q != 5'd0) begin
                    pos_d = pos_q - 5'd1;
                end
            end else begin
                acc_d = sum[3:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q      <= 2'b0;
            b_q      <= 2'b0;
            prev_q   <= 2'b0;
            up_q     <= 1'b0;
            dn_q     <= 1'b0;
            acc_q    <= 4'd0;
            div_q    <= '0;
            pos_q    <= RstPos;
            paddle_q <= mask(RstPos);
        end else begin
            a_q      <= {a_q[0], enc_a};
            b_q      <= {b_q[0], enc_b};
            prev_q   <= s;
            up_q     <= up_d;
            dn_q     <= dn_d;
            acc_q    <= acc_d;
            div_q    <= div_d;
            pos_q    <= pos_d;
            paddle_q <= mask(pos_q);
        end
    end

    assign pos    = pos_q;
    assign paddle = paddle_q;

endmodule
